// File: rtl/constants.sv
// constants_pkg: control-unit state encodings shared by the processor datapath.
package constants_pkg;
  localparam logic [4:0] S_RESET         = 5'd0;
  localparam logic [4:0] S_FETCH_INSTR   = 5'd1;
  localparam logic [4:0] S_DECODE        = 5'd2;
  localparam logic [4:0] S_FETCH_MEMORY  = 5'd3;
  localparam logic [4:0] S_STORE_MEMORY  = 5'd4;
  localparam logic [4:0] S_ALU_OPERATION = 5'd5;
  localparam logic [4:0] S_TEMP_FETCH    = 5'd6;
  localparam logic [4:0] S_TEMP_STORE    = 5'd7;
  localparam logic [4:0] S_WRITEBACK     = 5'd8;
  localparam logic [4:0] S_BRANCH        = 5'd9;
  localparam logic [4:0] S_HALT          = 5'd10;
endpackage

// File: rtl/mem_addr_pkg.sv
// mem_addr_pkg: sequencer FSM states, address-source enum and state-to-source mapping.
package mem_addr_pkg;
  import constants_pkg::*;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} fsm_e;
  typedef enum logic {SRC_PC = 1'b0, SRC_MAR = 1'b1} src_e;
  function automatic src_e src_of(logic [4:0] s);
    return (s == S_FETCH_MEMORY || s == S_STORE_MEMORY || s == S_TEMP_FETCH || s == S_TEMP_STORE)
      ? SRC_MAR : SRC_PC;
  endfunction
endpackage

// File: rtl/memory_address_sequencer_if.sv
// memory_address_sequencer_if: control/memory-side bus of the address sequencer.
interface memory_address_sequencer_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int MAX_BURST  = 4
);
  localparam int LW = $clog2(MAX_BURST + 1);
  localparam int BW = $clog2(MAX_BURST);
  logic [4:0]            state;
  logic [ADDR_WIDTH-1:0] pc_value;
  logic [ADDR_WIDTH-1:0] mar_value;
  logic                  access_start;
  logic [LW-1:0]         burst_len;
  logic                  mem_ready;
  logic [ADDR_WIDTH-1:0] address_bus;
  logic                  mem_req;
  logic                  busy;
  logic                  done;
  logic [BW-1:0]         beat_index;
  logic                  timeout_err;
  modport master (
    output state, pc_value, mar_value, access_start, burst_len, mem_ready,
    input  address_bus, mem_req, busy, done, beat_index, timeout_err
  );
  modport slave (
    input  state, pc_value, mar_value, access_start, burst_len, mem_ready,
    output address_bus, mem_req, busy, done, beat_index, timeout_err
  );
endinterface

// File: rtl/address_source_select.sv
// address_source_select: combinational control-state to address-source mux.
module address_source_select
  import mem_addr_pkg::*;
(
  input  logic [4:0] state_i,
  output src_e       src_o
);
  assign src_o = src_of(state_i);
endmodule

// File: rtl/memory_address_sequencer.sv
// memory_address_sequencer: registered PC/MAR address driver with ready handshake and bursts.
// Optional per-beat wait timeout enabled by defining MEM_TIMEOUT_EN.
module memory_address_sequencer
  import mem_addr_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int MAX_BURST      = 4,
  parameter int TIMEOUT_CYCLES = 15
) (
  input logic clock,
  input logic reset,
  memory_address_sequencer_if.slave bus
);
  localparam int LW = $clog2(MAX_BURST + 1);
  localparam int BW = $clog2(MAX_BURST);
  if (TIMEOUT_CYCLES < 1 || MAX_BURST < 2) begin : g_bad_cfg
    $error("memory_address_sequencer: unsupported TIMEOUT_CYCLES/MAX_BURST");
  end
  fsm_e                  fsm_q, fsm_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, base;
  logic [BW-1:0]         beat_q, beat_d, last_q, last_d, last_beat;
  logic                  tmo;
  src_e                  src;
  address_source_select u_src (.state_i(bus.state), .src_o(src));
  assign base = src == SRC_MAR ? bus.mar_value : bus.pc_value;
  // zero-length requests become one beat; oversize requests clamp to MAX_BURST
  assign last_beat = bus.burst_len == '0 ? '0
                   : bus.burst_len > LW'(MAX_BURST) ? BW'(MAX_BURST - 1)
                   : BW'(bus.burst_len - LW'(1));
  always_comb begin
    fsm_d  = fsm_q;
    addr_d = addr_q;
    beat_d = beat_q;
    last_d = last_q;
    case (fsm_q)
      IDLE: if (bus.access_start) begin
        fsm_d  = ACCESS;
        addr_d = base;
        beat_d = '0;
        last_d = last_beat;
      end
      ACCESS: if (bus.mem_ready && beat_q != last_q) begin
        addr_d = addr_q + ADDR_WIDTH'(1);
        beat_d = beat_q + BW'(1);
      end else if (bus.mem_ready || tmo) fsm_d = DONE;
      default: fsm_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      fsm_q  <= IDLE;
      addr_q <= '0;
      beat_q <= '0;
      last_q <= '0;
    end else begin
      fsm_q  <= fsm_d;
      addr_q <= addr_d;
      beat_q <= beat_d;
      last_q <= last_d;
    end
`ifdef MEM_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wait_q, wait_d;
  logic          terr_q, terr_d, stall;
  assign stall  = fsm_q == ACCESS && !bus.mem_ready;
  assign tmo    = stall && wait_q == WW'(TIMEOUT_CYCLES - 1);
  assign wait_d = stall ? wait_q + WW'(1) : '0;
  assign terr_d = fsm_q == IDLE && bus.access_start ? 1'b0 : tmo ? 1'b1 : terr_q;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wait_q <= '0;
      terr_q <= 1'b0;
    end else begin
      wait_q <= wait_d;
      terr_q <= terr_d;
    end
  assign bus.timeout_err = terr_q;
`else
  assign tmo             = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif
  assign bus.address_bus = addr_q;
  assign bus.mem_req     = fsm_q == ACCESS;
  assign bus.busy        = fsm_q != IDLE;
  assign bus.done        = fsm_q == DONE;
  assign bus.beat_index  = beat_q;
endmodule

// File: tb/tb_memory_address_sequencer.sv
// tb_memory_address_sequencer: table-driven accesses checked against a beat scoreboard.
module tb_memory_address_sequencer;
  import constants_pkg::*;
  logic clk, rst;
  int   n_cmp = 0, n_bad = 0;
  memory_address_sequencer_if #(.ADDR_WIDTH(16), .MAX_BURST(4)) bus ();
  memory_address_sequencer #(.ADDR_WIDTH(16), .MAX_BURST(4), .TIMEOUT_CYCLES(15)) dut (
    .clock(clk), .reset(rst), .bus(bus)
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  typedef struct {
    logic [4:0]  st;
    logic [15:0] pc;
    logic [15:0] mar;
    logic [2:0]  bl;
    int          waits;
    bit          poke;
    logic [15:0] base;
    int          beats;
  } vec_t;
  typedef struct {
    logic [15:0] addr;
    logic [1:0]  idx;
  } beat_t;
  beat_t sb[$];
  vec_t  vecs[7];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask
  task automatic run_access(input vec_t v);
    int    w, guard;
    beat_t last;
    last = '{16'h0, 2'h0};
    @(negedge clk);
    bus.state = v.st; bus.pc_value = v.pc; bus.mar_value = v.mar;
    bus.burst_len = v.bl; bus.access_start = 1'b1; bus.mem_ready = 1'b0;
    for (int i = 0; i < v.beats; i++) sb.push_back('{v.base + 16'(i), 2'(i)});
    @(negedge clk);
    bus.access_start = v.poke;
    if (v.poke) begin
      bus.pc_value = 16'h1234; bus.mar_value = 16'h5555; bus.state = S_HALT; bus.burst_len = 3'd1;
    end
    w = 0;
    guard = 0;
    while (sb.size() > 0 && guard < 64) begin
      chk("mem_req", 32'(bus.mem_req), 32'd1);
      chk("busy", 32'(bus.busy), 32'd1);
      chk("address_bus", 32'(bus.address_bus), 32'(sb[0].addr));
      chk("beat_index", 32'(bus.beat_index), 32'(sb[0].idx));
      bus.mem_ready = w >= v.waits;
      if (bus.mem_ready) last = sb.pop_front();
      w++;
      guard++;
      @(negedge clk);
    end
    if (guard >= 64) chk("beat_budget", 32'(guard), 32'd0);
    bus.mem_ready = 1'b0;
    chk("done_pulse", 32'(bus.done), 32'd1);
    chk("done_mem_req", 32'(bus.mem_req), 32'd0);
    chk("done_busy", 32'(bus.busy), 32'd1);
    chk("done_addr", 32'(bus.address_bus), 32'(last.addr));
    chk("done_timeout_err", 32'(bus.timeout_err), 32'd0);
    @(negedge clk);
    bus.access_start = 1'b0;
    chk("idle_done", 32'(bus.done), 32'd0);
    chk("idle_busy", 32'(bus.busy), 32'd0);
  endtask
  initial begin
    vecs[0] = '{S_FETCH_MEMORY,  16'h1111, 16'hffff, 3'd1, 0, 1'b0, 16'hffff, 1};
    vecs[1] = '{S_ALU_OPERATION, 16'habcd, 16'h2222, 3'd1, 3, 1'b0, 16'habcd, 1};
    vecs[2] = '{S_TEMP_FETCH,    16'h3333, 16'hfffe, 3'd4, 0, 1'b0, 16'hfffe, 4};
    vecs[3] = '{S_FETCH_INSTR,   16'h0100, 16'h7777, 3'd7, 0, 1'b1, 16'h0100, 4};
    vecs[4] = '{S_STORE_MEMORY,  16'h0101, 16'h8000, 3'd0, 0, 1'b0, 16'h8000, 1};
    vecs[5] = '{S_TEMP_STORE,    16'h0202, 16'h4000, 3'd2, 2, 1'b0, 16'h4000, 2};
    vecs[6] = '{S_DECODE,        16'h00ff, 16'h9999, 3'd3, 1, 1'b1, 16'h00ff, 3};
    rst = 1'b1;
    bus.state = S_RESET; bus.pc_value = '0; bus.mar_value = '0;
    bus.burst_len = '0; bus.access_start = 1'b0; bus.mem_ready = 1'b0;
    @(negedge clk);
    chk("rst_addr", 32'(bus.address_bus), 32'd0);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_beat", 32'(bus.beat_index), 32'd0);
    rst = 1'b0;
    foreach (vecs[i]) run_access(vecs[i]);
    @(negedge clk);
    bus.state = S_TEMP_FETCH; bus.mar_value = 16'h0010; bus.burst_len = 3'd4;
    bus.access_start = 1'b1; bus.mem_ready = 1'b1;
    @(negedge clk);
    bus.access_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_beat", 32'(bus.beat_index), 32'd2);
    chk("pre_reset_addr", 32'(bus.address_bus), 32'h0012);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_addr", 32'(bus.address_bus), 32'd0);
    chk("async_rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("async_rst_busy", 32'(bus.busy), 32'd0);
    chk("async_rst_done", 32'(bus.done), 32'd0);
    chk("async_rst_beat", 32'(bus.beat_index), 32'd0);
    chk("async_rst_terr", 32'(bus.timeout_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.mem_ready = 1'b0;
    sb.delete();
    run_access(vecs[5]);
`ifdef MEM_TIMEOUT_EN
    begin
      int stalls;
      stalls = 0;
      @(negedge clk);
      bus.state = S_FETCH_INSTR; bus.pc_value = 16'h0042; bus.burst_len = 3'd1;
      bus.access_start = 1'b1; bus.mem_ready = 1'b0;
      @(negedge clk);
      bus.access_start = 1'b0;
      while (bus.mem_req && stalls < 40) begin
        stalls++;
        @(negedge clk);
      end
      chk("timeout_wait_cycles", 32'(stalls), 32'd15);
      chk("timeout_done", 32'(bus.done), 32'd1);
      chk("timeout_err_set", 32'(bus.timeout_err), 32'd1);
      @(negedge clk);
      chk("timeout_err_hold", 32'(bus.timeout_err), 32'd1);
      run_access(vecs[0]);
    end
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
